// File: rtl/light_part_update_if.sv
// Counter-RAM bus between the light-part read stage and the update stage:
// snooped read enables/addresses, returned read data and the write-back port.
interface light_part_update_if #(
  parameter int CW = 8,
  parameter int AW = 16
);
  logic [7:0]      rden_in;
  logic [8*AW-1:0] rdaddr_in;
  logic [8*CW-1:0] rddata_in;
  logic [7:0]      wren_out;
  logic [8*AW-1:0] wraddr_out;
  logic [8*CW-1:0] wrdata_out;

  modport master (
    output rden_in, rdaddr_in, rddata_in,
    input  wren_out, wraddr_out, wrdata_out
  );

  modport slave (
    input  rden_in, rdaddr_in, rddata_in,
    output wren_out, wraddr_out, wrdata_out
  );
endinterface

// File: rtl/light_part_update.sv
// Light-part read-modify-write stage: saturating +1 on each counter read across
// 8 banks, with write forwarding and an epoch-clear sweep of all banks.
module light_part_update #(
  parameter int CW     = 8,
  parameter int AW     = 16,
  parameter int RD_LAT = 2,
  parameter int DEPTH  = 65536
) (
  input  logic                clk,
  input  logic                reset,
  light_part_update_if.slave  bus,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                clear_done,
  output logic [31:0]         sat_cnt,
  output logic                err_rd_busy
);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  localparam logic [CW-1:0] MAX  = '1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_clr_addr;

  logic            r_vld_p  [8][RD_LAT];
  logic [AW-1:0]   r_addr_p [8][RD_LAT];
  logic            r_h_vld  [8][RD_LAT];
  logic [AW-1:0]   r_h_addr [8][RD_LAT];
  logic [CW-1:0]   r_h_data [8][RD_LAT];

  logic [7:0]      r_wren;
  logic [AW-1:0]   r_wraddr [8];
  logic [CW-1:0]   r_wrdata [8];

  logic [7:0]      w_acc;
  logic [CW-1:0]   w_base [8];
  logic [7:0]      w_sat;
  logic [3:0]      w_sat_n;
  logic            w_pipe_vld;
  logic            w_empty;
  logic            w_clr_entry;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + CW'(1);
  endfunction

  assign clear_busy  = (r_state != IDLE);
  assign w_acc       = clear_busy ? 8'h00 : bus.rden_in;
  assign w_empty     = !w_pipe_vld && (w_acc == 8'h00);
  assign w_clr_entry = (r_state != CLEAR) && (w_state_nxt == CLEAR);

  // Base value: RAM data, overridden by the newest write the RAM could not yet reflect.
  always_comb begin
    w_pipe_vld = |r_wren;
    w_sat_n    = '0;
    for (int b = 0; b < 8; b++) begin
      w_base[b] = bus.rddata_in[b*CW +: CW];
      for (int k = RD_LAT - 1; k >= 0; k--) begin
        if (r_h_vld[b][k] && r_h_addr[b][k] == r_addr_p[b][RD_LAT-1])
          w_base[b] = r_h_data[b][k];
        w_pipe_vld = w_pipe_vld | r_vld_p[b][k];
      end
      if (r_wren[b] && r_wraddr[b] == r_addr_p[b][RD_LAT-1])
        w_base[b] = r_wrdata[b];
      w_sat[b] = r_vld_p[b][RD_LAT-1] && (w_base[b] == MAX);
      w_sat_n  = w_sat_n + 4'(w_sat[b]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clear_start) w_state_nxt = w_empty ? CLEAR : DRAIN;
      DRAIN:   if (w_empty) w_state_nxt = CLEAR;
      CLEAR:   if (r_clr_addr == LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.wren_out   = r_wren;
    bus.wraddr_out = '0;
    bus.wrdata_out = '0;
    for (int b = 0; b < 8; b++) begin
      bus.wraddr_out[b*AW +: AW] = r_wraddr[b];
      bus.wrdata_out[b*CW +: CW] = r_wrdata[b];
    end
    if (r_state == CLEAR) begin
      bus.wren_out   = 8'hFF;
      bus.wraddr_out = {8{r_clr_addr}};
      bus.wrdata_out = '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_clr_addr  <= '0;
      clear_done  <= 1'b0;
      sat_cnt     <= '0;
      err_rd_busy <= 1'b0;
      r_wren      <= '0;
      for (int b = 0; b < 8; b++) begin
        r_wraddr[b] <= '0;
        r_wrdata[b] <= '0;
        for (int k = 0; k < RD_LAT; k++) begin
          r_vld_p[b][k] <= 1'b0;
          r_h_vld[b][k] <= 1'b0;
        end
      end
    end else begin
      r_state    <= w_state_nxt;
      clear_done <= (r_state == CLEAR) && (r_clr_addr == LAST);
      if (r_state == CLEAR)
        r_clr_addr <= (r_clr_addr == LAST) ? '0 : r_clr_addr + AW'(1);
      sat_cnt <= sat_cnt + 32'(w_sat_n);
      if (clear_busy && (bus.rden_in != 8'h00))
        err_rd_busy <= 1'b1;
      for (int b = 0; b < 8; b++) begin
        r_vld_p[b][0] <= w_acc[b];
        for (int k = 1; k < RD_LAT; k++)
          r_vld_p[b][k] <= r_vld_p[b][k-1];
        r_wren[b] <= r_vld_p[b][RD_LAT-1];
        if (r_vld_p[b][RD_LAT-1]) begin
          r_wraddr[b] <= r_addr_p[b][RD_LAT-1];
          r_wrdata[b] <= sat_inc(w_base[b]);
        end
        r_h_vld[b][0] <= r_wren[b] && !w_clr_entry;
        for (int k = 1; k < RD_LAT; k++)
          r_h_vld[b][k] <= r_h_vld[b][k-1] && !w_clr_entry;
      end
    end
  end

  // Address/data pipeline and write history; qualified by the valid bits above.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      r_addr_p[b][0] <= bus.rdaddr_in[b*AW +: AW];
      for (int k = 1; k < RD_LAT; k++)
        r_addr_p[b][k] <= r_addr_p[b][k-1];
      r_h_addr[b][0] <= r_wraddr[b];
      r_h_data[b][0] <= r_wrdata[b];
      for (int k = 1; k < RD_LAT; k++) begin
        r_h_addr[b][k] <= r_h_addr[b][k-1];
        r_h_data[b][k] <= r_h_data[b][k-1];
      end
    end
  end

endmodule

// File: tb/tb_light_part_update.sv
// Directed bench for light_part_update: single update, hazard forwarding,
// saturation, drain + clear sweep, read-while-busy error and mid-sweep reset.
module tb_light_part_update;
  localparam int CW = 8, AW = 16, RD_LAT = 2, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_start = 1'b0;
  logic clear_busy, clear_done, err_rd_busy;
  logic [31:0] sat_cnt;
  logic [8*CW-1:0] rdv = '0;
  logic [8*CW-1:0] dq0 = '0;
  logic [8*CW-1:0] dq1 = '0;
  int total = 0;
  int bad = 0;
  logic seen;

  always #5 clk = ~clk;

  light_part_update_if #(.CW(CW), .AW(AW)) bus();

  light_part_update #(.CW(CW), .AW(AW), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .sat_cnt(sat_cnt), .err_rd_busy(err_rd_busy)
  );

  // RAM read data returns RD_LAT cycles after the read was issued.
  always @(posedge clk) begin
    dq0 <= rdv;
    dq1 <= dq0;
  end
  assign bus.rddata_in = dq1;

  always @(negedge clk)
    if (rst_n)
      assert ($onehot0(bus.rden_in)) else begin
        bad++;
        $error("FAIL onehot_rden observed=%h expected=one-hot-or-zero", bus.rden_in);
      end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int b, input logic [AW-1:0] a, input logic [CW-1:0] v);
    bus.rden_in = 8'(1 << b);
    bus.rdaddr_in[b*AW +: AW] = a;
    rdv[b*CW +: CW] = v;
  endtask

  task automatic idle();
    bus.rden_in = 8'h00;
  endtask

  function automatic logic [AW-1:0] wa(input int b);
    return bus.wraddr_out[b*AW +: AW];
  endfunction

  function automatic logic [CW-1:0] wd(input int b);
    return bus.wrdata_out[b*CW +: CW];
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rden_in = 8'h00;
    bus.rdaddr_in = '0;
    tick(); tick();
    chk("rst_wren", bus.wren_out, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_err", err_rd_busy, 0);
    chk("rst_wraddr", wa(0), 0);
    rst_n = 1'b1;
    tick(); tick();

    // Single update, latency RD_LAT+1
    issue(2, 16'h0010, 8'h05); tick();
    idle(); tick();
    chk("t1_early", bus.wren_out, 0); tick();
    chk("t1_wren", bus.wren_out, 8'h04);
    chk("t1_addr", wa(2), 16'h0010);
    chk("t1_data", wd(2), 8'h06); tick();
    chk("t1_once", bus.wren_out, 0);

    // Back-to-back same-address reads on one bank
    issue(0, 16'h0007, 8'h00); tick();
    issue(0, 16'h0007, 8'h00); tick();
    issue(0, 16'h0007, 8'h00); tick();
    idle();
    chk("t2_wren0", bus.wren_out, 8'h01);
    chk("t2_addr", wa(0), 16'h0007);
    chk("t2_d0", wd(0), 8'h01); tick();
    chk("t2_d1", wd(0), 8'h02);
    chk("t2_wren1", bus.wren_out, 8'h01); tick();
    chk("t2_d2", wd(0), 8'h03); tick();
    chk("t2_end", bus.wren_out, 0);

    // Saturation
    issue(1, 16'h0020, 8'hFF); tick();
    idle(); tick();
    chk("t3_sat_pre", sat_cnt, 0); tick();
    chk("t3_wren", bus.wren_out, 8'h02);
    chk("t3_data", wd(1), 8'hFF);
    chk("t3_sat1", sat_cnt, 1); tick();
    issue(3, 16'h0030, 8'hFE); tick();
    issue(3, 16'h0030, 8'hFE); tick();
    idle(); tick();
    chk("t3_fe_wren", bus.wren_out, 8'h08);
    chk("t3_fe_data", wd(3), 8'hFF);
    chk("t3_fe_sat", sat_cnt, 1); tick();
    chk("t3_fwd_data", wd(3), 8'hFF);
    chk("t3_fwd_sat", sat_cnt, 2); tick();

    // Clear with two updates in flight, plus a dropped read at the end
    issue(4, 16'h0040, 8'h11); tick();
    issue(5, 16'h0050, 8'h22); clear_start = 1'b1; tick();
    idle(); clear_start = 1'b0;
    chk("t4_busy", clear_busy, 1);
    chk("t4_nowr", bus.wren_out, 0); tick();
    chk("t4_w4", bus.wren_out, 8'h10);
    chk("t4_a4", wa(4), 16'h0040);
    chk("t4_d4", wd(4), 8'h12); tick();
    chk("t4_w5", bus.wren_out, 8'h20);
    chk("t4_a5", wa(5), 16'h0050);
    chk("t4_d5", wd(5), 8'h23); tick();
    chk("t4_drained", bus.wren_out, 0);
    chk("t4_busy2", clear_busy, 1); tick();
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t4_cw%0d", i), bus.wren_out, 8'hFF);
      chk($sformatf("t4_ca0_%0d", i), wa(0), 64'(i));
      chk($sformatf("t4_ca7_%0d", i), wa(7), 64'(i));
      chk($sformatf("t4_cd_%0d", i), bus.wrdata_out, 0);
      chk($sformatf("t4_cdone_%0d", i), clear_done, 0);
      clear_start = (i == 3);
      if (i == DEPTH - 1) issue(0, 16'h0099, 8'h55);
      else idle();
      tick();
    end
    idle(); clear_start = 1'b0;
    chk("t4_done", clear_done, 1);
    chk("t4_busy_lo", clear_busy, 0);
    chk("t4_post0", bus.wren_out, 0);
    chk("t5_err", err_rd_busy, 1); tick();
    chk("t4_done_once", clear_done, 0);
    chk("t5_post1", bus.wren_out, 0); tick();
    chk("t5_post2", bus.wren_out, 0); tick();
    chk("t5_post3", bus.wren_out, 0);
    chk("t5_sticky", err_rd_busy, 1); tick();

    // Reset in the middle of a sweep
    clear_start = 1'b1; tick();
    clear_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_a%0d", i), wa(3), 64'(i));
      if (i < 5) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wren", bus.wren_out, 0);
    chk("t6_busy", clear_busy, 0);
    chk("t6_addr", wa(3), 0);
    chk("t6_err", err_rd_busy, 0);
    chk("t6_sat", sat_cnt, 0);
    chk("t6_done", clear_done, 0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clear_done) seen = 1'b1;
    end
    chk("t6_nodone", seen, 0);
    clear_start = 1'b1; tick();
    clear_start = 1'b0;
    chk("t6_restart_w", bus.wren_out, 8'hFF);
    chk("t6_restart_a", wa(0), 0);
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("t6_last_a", wa(6), 64'(DEPTH - 1)); tick();
    chk("t6_done2", clear_done, 1);
    chk("t6_busy2", clear_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
